// File: rtl/disp_view_sched.sv
// Display view scheduler: latches temperature/humidity words and rotates which one drives the 7-segment converter.
// Optional stale-reading indication is built when DISP_STALE_EN is defined.
module disp_view_sched #(
  parameter int unsigned DWELL_TICKS = 200_000_000,
  parameter int unsigned STALE_TICKS = 500_000_000,
  parameter int unsigned CNT_W       = 29
) (
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  input  logic        temp_valid,
  output logic        temp_ack,
  input  logic [15:0] hum_raw,
  input  logic        hum_valid,
  output logic        hum_ack,
  input  logic        hold,
  output logic [15:0] data_out,
  output logic        sel_hum,
  output logic        view_chg,
  output logic        stale
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW_T = 2'd1,
    ST_SHOW_H = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 32'd1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   dwell_r, dwell_s;
  logic [15:0]        temp_q_r, hum_q_r;
  logic               has_temp_r, has_hum_r;
  logic [15:0]        show_data_s;
  logic               stale_s;
  logic [15:0]        data_out_r;
  logic               sel_hum_r, view_chg_r, stale_r, temp_ack_r, hum_ack_r;

  // Next view and dwell count; rotation only lands on a channel that has a sample
  always_comb begin
    state_s = state_r;
    dwell_s = dwell_r;
    case (state_r)
      ST_IDLE: begin
        dwell_s = CNT_W'(0);
        if (temp_valid) begin
          state_s = ST_SHOW_T;
        end else if (hum_valid) begin
          state_s = ST_SHOW_H;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHOW_T: begin
        if (hold) begin
          dwell_s = dwell_r;
        end else if (dwell_r >= DWELL_LAST) begin
          dwell_s = CNT_W'(0);
          if (has_hum_r) begin
            state_s = ST_SHOW_H;
          end else begin
            state_s = ST_SHOW_T;
          end
        end else begin
          dwell_s = dwell_r + CNT_W'(1);
        end
      end
      ST_SHOW_H: begin
        if (hold) begin
          dwell_s = dwell_r;
        end else if (dwell_r >= DWELL_LAST) begin
          dwell_s = CNT_W'(0);
          if (has_temp_r) begin
            state_s = ST_SHOW_T;
          end else begin
            state_s = ST_SHOW_H;
          end
        end else begin
          dwell_s = dwell_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        dwell_s = CNT_W'(0);
      end
    endcase
  end

  // Word presented for the current view
  always_comb begin
    show_data_s = 16'h0000;
    case (state_r)
      ST_SHOW_T: show_data_s = temp_q_r;
      ST_SHOW_H: show_data_s = hum_q_r;
      default:   show_data_s = 16'h0000;
    endcase
  end

`ifdef DISP_STALE_EN
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_TICKS);

  logic [CNT_W-1:0] age_t_r, age_h_r;

  // Per-channel sample age, saturating at the stale threshold
  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      age_t_r <= CNT_W'(0);
      age_h_r <= CNT_W'(0);
    end else begin
      if (temp_valid) begin
        age_t_r <= CNT_W'(0);
      end else if (age_t_r < STALE_MAX) begin
        age_t_r <= age_t_r + CNT_W'(1);
      end else begin
        age_t_r <= age_t_r;
      end
      if (hum_valid) begin
        age_h_r <= CNT_W'(0);
      end else if (age_h_r < STALE_MAX) begin
        age_h_r <= age_h_r + CNT_W'(1);
      end else begin
        age_h_r <= age_h_r;
      end
    end
  end

  // Staleness of whichever channel the current view shows
  always_comb begin
    stale_s = 1'b0;
    case (state_r)
      ST_SHOW_T: stale_s = (age_t_r == STALE_MAX);
      ST_SHOW_H: stale_s = (age_h_r == STALE_MAX);
      default:   stale_s = 1'b0;
    endcase
  end
`else
  // Staleness tracking not built
  always_comb begin
    stale_s = 1'b0;
  end
`endif

  // State, sample capture and registered outputs
  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      dwell_r    <= CNT_W'(0);
      temp_q_r   <= 16'h0000;
      hum_q_r    <= 16'h0000;
      has_temp_r <= 1'b0;
      has_hum_r  <= 1'b0;
      data_out_r <= 16'h0000;
      sel_hum_r  <= 1'b0;
      view_chg_r <= 1'b0;
      stale_r    <= 1'b0;
      temp_ack_r <= 1'b0;
      hum_ack_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dwell_r <= dwell_s;
      if (temp_valid) begin
        temp_q_r   <= temp_raw;
        has_temp_r <= 1'b1;
      end else begin
        temp_q_r   <= temp_q_r;
        has_temp_r <= has_temp_r;
      end
      if (hum_valid) begin
        hum_q_r   <= hum_raw;
        has_hum_r <= 1'b1;
      end else begin
        hum_q_r   <= hum_q_r;
        has_hum_r <= has_hum_r;
      end
      // Outputs trail the view by one edge so data_out and sel_hum stay aligned
      data_out_r <= show_data_s;
      view_chg_r <= (show_data_s != data_out_r);
      sel_hum_r  <= (state_r == ST_SHOW_H);
      stale_r    <= stale_s;
      temp_ack_r <= temp_valid;
      hum_ack_r  <= hum_valid;
    end
  end

  assign temp_ack = temp_ack_r;
  assign hum_ack  = hum_ack_r;
  assign data_out = data_out_r;
  assign sel_hum  = sel_hum_r;
  assign view_chg = view_chg_r;
  assign stale    = stale_r;

endmodule

// File: tb/tb_disp_view_sched.sv
// Scoreboard bench for disp_view_sched: a behavioural model queues expected outputs each edge,
// a monitor compares them on the following falling edge.
module tb_disp_view_sched;

  localparam int DW = 8;
  localparam int ST = 20;
`ifdef DISP_STALE_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif

  logic        clk100MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] temp_raw = 16'h0000;
  logic        temp_valid = 1'b0;
  logic        temp_ack;
  logic [15:0] hum_raw = 16'h0000;
  logic        hum_valid = 1'b0;
  logic        hum_ack;
  logic        hold = 1'b0;
  logic [15:0] data_out;
  logic        sel_hum;
  logic        view_chg;
  logic        stale;

  always #5 clk100MHz = ~clk100MHz;

  disp_view_sched #(.DWELL_TICKS(DW), .STALE_TICKS(ST), .CNT_W(29)) dut (
    .clk100MHz(clk100MHz), .rst_n(rst_n),
    .temp_raw(temp_raw), .temp_valid(temp_valid), .temp_ack(temp_ack),
    .hum_raw(hum_raw), .hum_valid(hum_valid), .hum_ack(hum_ack),
    .hold(hold), .data_out(data_out), .sel_hum(sel_hum),
    .view_chg(view_chg), .stale(stale)
  );

  typedef struct packed {
    logic        ta;
    logic        ha;
    logic [15:0] d;
    logic        sel;
    logic        chg;
    logic        stl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  // Reference model: view is 0 (nothing yet), 1 (temperature) or 2 (humidity)
  int          m_view = 0, m_dwell = 0, m_age_t = 0, m_age_h = 0;
  bit          m_has_t = 1'b0, m_has_h = 1'b0;
  logic [15:0] m_tq = 16'h0000, m_hq = 16'h0000, m_prev = 16'h0000;

  initial begin
    forever begin
      exp_t e;
      int   other;
      bit   other_has;
      @(posedge clk100MHz);
      started = 1'b1;
      if (!rst_n) begin
        e = '0;
        m_view = 0; m_dwell = 0; m_age_t = 0; m_age_h = 0;
        m_has_t = 1'b0; m_has_h = 1'b0;
        m_tq = 16'h0000; m_hq = 16'h0000; m_prev = 16'h0000;
      end else begin
        e.ta  = temp_valid;
        e.ha  = hum_valid;
        e.d   = (m_view == 1) ? m_tq : (m_view == 2) ? m_hq : 16'h0000;
        e.chg = (e.d != m_prev);
        m_prev = e.d;
        e.sel = (m_view == 2);
        e.stl = STALE_EN && (((m_view == 1) && (m_age_t == ST)) ||
                             ((m_view == 2) && (m_age_h == ST)));
        if (m_view == 0) begin
          if (temp_valid) m_view = 1;
          else if (hum_valid) m_view = 2;
          m_dwell = 0;
        end else if (!hold) begin
          if (m_dwell == DW - 1) begin
            m_dwell = 0;
            other = (m_view == 1) ? 2 : 1;
            other_has = (other == 1) ? m_has_t : m_has_h;
            if (other_has) m_view = other;
          end else begin
            m_dwell = m_dwell + 1;
          end
        end
        if (temp_valid) begin m_tq = temp_raw; m_has_t = 1'b1; end
        if (hum_valid)  begin m_hq = hum_raw;  m_has_h = 1'b1; end
        m_age_t = temp_valid ? 0 : ((m_age_t < ST) ? m_age_t + 1 : m_age_t);
        m_age_h = hum_valid  ? 0 : ((m_age_h < ST) ? m_age_h + 1 : m_age_h);
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected record per rising edge, checked mid-cycle
  initial begin
    forever begin
      exp_t e;
      @(negedge clk100MHz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("temp_ack", {15'd0, temp_ack}, {15'd0, e.ta});
        chk("hum_ack",  {15'd0, hum_ack},  {15'd0, e.ha});
        chk("data_out", data_out, e.d);
        chk("sel_hum",  {15'd0, sel_hum},  {15'd0, e.sel});
        chk("view_chg", {15'd0, view_chg}, {15'd0, e.chg});
        chk("stale",    {15'd0, stale},    {15'd0, e.stl});
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected a record at %0t", $time);
      end
    end
  end

  task automatic cyc(input bit tv, input logic [15:0] tr, input bit hv, input logic [15:0] hr,
                     input bit hd, input bit rn);
    temp_valid = tv; temp_raw = tr;
    hum_valid  = hv; hum_raw  = hr;
    hold = hd; rst_n = rn;
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic idle(input int n, input bit hd);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, hd, 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    bit hd;
    do_reset();
    // first temperature sample, then humidity, then rotation
    cyc(1'b1, 16'h6666, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(5, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    idle(20, 1'b0);
    // only temperature: no rotation, goes stale, then refreshes
    do_reset();
    cyc(1'b1, 16'h0042, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(30, 1'b0);
    cyc(1'b1, 16'h0043, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(4, 1'b0);
    // both strobes together from idle
    do_reset();
    cyc(1'b1, 16'h1234, 1'b1, 16'hABCD, 1'b0, 1'b1);
    idle(20, 1'b0);
    // hold at dwell count 3 for 20 clocks
    do_reset();
    cyc(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(20, 1'b1);
    idle(12, 1'b0);
    // reset mid-display
    cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(4, 1'b0);
    // randomized traffic with occasional hold and reset
    hd = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) hd = ~hd;
      cyc($urandom_range(0, 11) == 0, 16'($urandom), $urandom_range(0, 13) == 0, 16'($urandom),
          hd, $urandom_range(0, 499) != 0);
    end
    idle(3, 1'b0);
    @(negedge clk100MHz);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
